// File: rtl/deck_dealer_pkg.sv
// Shared deck constants and dealer state encoding.
// Imported by shuffle stage, dealer and game controller.
package deck_dealer_pkg;

  localparam int unsigned DECK_SIZE = 52;
  localparam int unsigned SUIT_SIZE = 13;
  localparam int unsigned RESHUFFLE_THRESHOLD = 15;

  localparam logic [3:0] ACE_POINTS = 4'd11;
  localparam logic [3:0] FACE_POINTS = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY,
    EMPTY
  } dealer_state_t;

endpackage

// File: rtl/card_decode.sv
// Card code to rank, suit and blackjack points.
// Pure combinational; also used for hand display.
module card_decode
  import deck_dealer_pkg::*;
(
  input  logic [5:0] code,
  output logic [3:0] rank,
  output logic [1:0] suit,
  output logic [3:0] points
);

  localparam logic [5:0] S1 = 6'(SUIT_SIZE);
  localparam logic [5:0] S2 = 6'(2 * SUIT_SIZE);
  localparam logic [5:0] S3 = 6'(3 * SUIT_SIZE);

  logic [5:0] base;
  logic [5:0] idx;

  // Suit by range compare, rank from offset into suit.
  always_comb begin
    suit = 2'd0;
    base = 6'd0;
    unique case (1'b1)
      (code < S1): begin
        suit = 2'd0;
        base = 6'd0;
      end
      (code >= S1 && code < S2): begin
        suit = 2'd1;
        base = S1;
      end
      (code >= S2 && code < S3): begin
        suit = 2'd2;
        base = S2;
      end
      (code >= S3): begin
        suit = 2'd3;
        base = S3;
      end
    endcase
    idx = code - base;
    rank = idx[3:0] + 4'd1;
    points = rank;
    if (rank == 4'd1) begin
      points = ACE_POINTS;
    end else if (rank >= 4'd10) begin
      points = FACE_POINTS;
    end
  end

endmodule

// File: rtl/deck_dealer.sv
// Captures a shuffled deck, checks it is a permutation,
// and deals cards on request with decoded rank/suit/points.
module deck_dealer
  import deck_dealer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       card_valid,
  input  logic [5:0] card_in,
  input  logic       deal_req,
  input  logic       new_deck,
  output logic       shuffle_req,
  output logic       deck_ready,
  output logic       deal_valid,
  output logic [5:0] deal_card,
  output logic [3:0] deal_rank,
  output logic [1:0] deal_suit,
  output logic [3:0] deal_points,
  output logic [5:0] cards_left,
  output logic       low_deck,
  output logic       deal_error,
  output logic       load_error
);

  localparam logic [5:0] FULL = 6'(DECK_SIZE);
  localparam logic [5:0] LAST = 6'(DECK_SIZE - 1);
  localparam logic [5:0] LOW = 6'(RESHUFFLE_THRESHOLD);

  dealer_state_t state;
  logic [5:0] wr_ptr;
  logic [5:0] rd_ptr;
  logic [63:0] seen;
  logic [5:0] deck [DECK_SIZE];

  logic [5:0] head;
  logic [3:0] head_rank;
  logic [1:0] head_suit;
  logic [3:0] head_points;
  logic loading;
  logic card_bad;
  logic card_take;

  assign loading = (state == IDLE || state == LOAD)
                && card_valid && !new_deck;
  assign card_bad = (card_in >= FULL) || seen[card_in];
  assign card_take = loading && !card_bad;
  assign head = deck[rd_ptr];
  assign low_deck = (state == READY) && (cards_left <= LOW);

  card_decode u_decode (
    .code   (head),
    .rank   (head_rank),
    .suit   (head_suit),
    .points (head_points)
  );

  // Deck storage; validity is tracked by seen/wr_ptr.
  always_ff @(posedge clk) begin
    if (card_take) begin
      deck[wr_ptr] <= card_in;
    end
  end

  // Load / deal state machine with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      seen <= '0;
      cards_left <= '0;
      deal_valid <= 1'b0;
      deal_card <= '0;
      deal_rank <= '0;
      deal_suit <= '0;
      deal_points <= '0;
      deck_ready <= 1'b0;
      deal_error <= 1'b0;
      load_error <= 1'b0;
      shuffle_req <= 1'b0;
    end else begin
      deal_valid <= 1'b0;
      deal_error <= 1'b0;
      if (new_deck) begin
        state <= IDLE;
        wr_ptr <= '0;
        rd_ptr <= '0;
        seen <= '0;
        cards_left <= '0;
        deck_ready <= 1'b0;
        load_error <= 1'b0;
        shuffle_req <= 1'b0;
      end else begin
        unique case (state)
          IDLE, LOAD: begin
            shuffle_req <= 1'b1;
            if (deal_req) begin
              deal_error <= 1'b1;
            end
            if (card_valid) begin
              state <= LOAD;
              if (card_bad) begin
                load_error <= 1'b1;
              end else begin
                seen[card_in] <= 1'b1;
                wr_ptr <= wr_ptr + 6'd1;
                if (wr_ptr == LAST) begin
                  state <= READY;
                  deck_ready <= 1'b1;
                  shuffle_req <= 1'b0;
                  cards_left <= FULL;
                  rd_ptr <= '0;
                end
              end
            end
          end
          READY: begin
            if (deal_req) begin
              deal_valid <= 1'b1;
              deal_card <= head;
              deal_rank <= head_rank;
              deal_suit <= head_suit;
              deal_points <= head_points;
              rd_ptr <= rd_ptr + 6'd1;
              cards_left <= cards_left - 6'd1;
              if (cards_left == 6'd1) begin
                state <= EMPTY;
                deck_ready <= 1'b0;
              end
            end
          end
          EMPTY: begin
            if (deal_req) begin
              deal_error <= 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_deck_dealer.sv
// Directed bench for deck_dealer: load, deal, errors,
// new_deck priority and mid-load reset.
module tb_deck_dealer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic card_valid = 1'b0;
  logic [5:0] card_in = '0;
  logic deal_req = 1'b0;
  logic new_deck = 1'b0;
  logic shuffle_req, deck_ready, deal_valid;
  logic [5:0] deal_card, cards_left;
  logic [3:0] deal_rank, deal_points;
  logic [1:0] deal_suit;
  logic low_deck, deal_error, load_error;

  typedef struct {
    int card;
    int rank;
    int suit;
    int points;
  } vec_t;

  vec_t tbl[12];
  int order[$];
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  deck_dealer dut (
    .clk         (clk),
    .rst         (rst),
    .card_valid  (card_valid),
    .card_in     (card_in),
    .deal_req    (deal_req),
    .new_deck    (new_deck),
    .shuffle_req (shuffle_req),
    .deck_ready  (deck_ready),
    .deal_valid  (deal_valid),
    .deal_card   (deal_card),
    .deal_rank   (deal_rank),
    .deal_suit   (deal_suit),
    .deal_points (deal_points),
    .cards_left  (cards_left),
    .low_deck    (low_deck),
    .deal_error  (deal_error),
    .load_error  (load_error)
  );

  task automatic chk(string name, int got, int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d",
                  name, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(int c);
    card_in = 6'(c);
    card_valid = 1'b1;
    cyc();
    card_valid = 1'b0;
  endtask

  task automatic deal();
    deal_req = 1'b1;
    cyc();
    deal_req = 1'b0;
  endtask

  function automatic int exp_pts(int c);
    int r;
    r = (c % 13) + 1;
    if (r == 1) return 11;
    if (r >= 10) return 10;
    return r;
  endfunction

  task automatic chk_idle_outs(string tag);
    chk({tag, " shuffle_req"}, int'(shuffle_req), 0);
    chk({tag, " deck_ready"}, int'(deck_ready), 0);
    chk({tag, " cards_left"}, int'(cards_left), 0);
    chk({tag, " load_error"}, int'(load_error), 0);
    chk({tag, " deal_valid"}, int'(deal_valid), 0);
    chk({tag, " deal_card"}, int'(deal_card), 0);
    chk({tag, " deal_error"}, int'(deal_error), 0);
  endtask

  initial begin
    bit used[64];
    int c;
    int left;
    tbl[0] = '{0, 1, 0, 11};
    tbl[1] = '{25, 13, 1, 10};
    tbl[2] = '{51, 13, 3, 10};
    tbl[3] = '{9, 10, 0, 10};
    tbl[4] = '{10, 11, 0, 10};
    tbl[5] = '{8, 9, 0, 9};
    tbl[6] = '{13, 1, 1, 11};
    tbl[7] = '{38, 13, 2, 10};
    tbl[8] = '{39, 1, 3, 11};
    tbl[9] = '{27, 2, 2, 2};
    tbl[10] = '{50, 12, 3, 10};
    tbl[11] = '{21, 9, 1, 9};

    order.push_back(7);
    used[7] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      order.push_back(tbl[i].card);
      used[tbl[i].card] = 1'b1;
    end
    for (int i = 0; i < 52; i++)
      if (!used[i]) order.push_back(i);

    // reset state
    #2 rst = 1'b0;
    #1;
    chk_idle_outs("reset");
    chk("reset low_deck", int'(low_deck), 0);
    cyc();
    rst = 1'b1;
    cyc();
    cyc();
    chk("idle shuffle_req", int'(shuffle_req), 1);

    // load 51..0, one card every 2 cycles
    for (int k = 51; k >= 0; k--) begin
      chk("load shuffle_req", int'(shuffle_req), 1);
      chk("load deck_ready", int'(deck_ready), 0);
      send(k);
      if (k != 0) cyc();
    end
    chk("full deck_ready", int'(deck_ready), 1);
    chk("full shuffle_req", int'(shuffle_req), 0);
    chk("full cards_left", int'(cards_left), 52);
    chk("full load_error", int'(load_error), 0);
    chk("full low_deck", int'(low_deck), 0);

    // 52 back-to-back deals, then one too many
    deal_req = 1'b1;
    for (int i = 0; i < 52; i++) begin
      cyc();
      c = 51 - i;
      left = 51 - i;
      chk("b2b deal_valid", int'(deal_valid), 1);
      chk("b2b deal_card", int'(deal_card), c);
      chk("b2b rank", int'(deal_rank), (c % 13) + 1);
      chk("b2b suit", int'(deal_suit), c / 13);
      chk("b2b points", int'(deal_points), exp_pts(c));
      chk("b2b cards_left", int'(cards_left), left);
      chk("b2b low_deck", int'(low_deck),
          (left <= 15 && left > 0) ? 1 : 0);
      chk("b2b deal_error", int'(deal_error), 0);
    end
    chk("empty deck_ready", int'(deck_ready), 0);
    cyc();
    deal_req = 1'b0;
    chk("empty deal_error", int'(deal_error), 1);
    chk("empty deal_valid", int'(deal_valid), 0);
    chk("empty hold card", int'(deal_card), 0);
    chk("empty cards_left", int'(cards_left), 0);
    cyc();
    chk("empty err pulse", int'(deal_error), 0);
    chk("empty shuffle_req", int'(shuffle_req), 0);

    // new_deck from EMPTY
    new_deck = 1'b1;
    cyc();
    new_deck = 1'b0;
    chk("nd deck_ready", int'(deck_ready), 0);
    chk("nd shuffle_req t1", int'(shuffle_req), 0);
    cyc();
    chk("nd shuffle_req t2", int'(shuffle_req), 1);
    deal();
    chk("idle deal_error", int'(deal_error), 1);
    chk("idle deal_valid", int'(deal_valid), 0);

    // duplicate and out-of-range cards during load
    send(7);
    send(7);
    send(60);
    chk("dup load_error", int'(load_error), 1);
    for (int i = 1; i < 51; i++) send(order[i]);
    chk("51 deck_ready", int'(deck_ready), 0);
    chk("51 cards_left", int'(cards_left), 0);
    chk("51 shuffle_req", int'(shuffle_req), 1);
    send(order[51]);
    chk("52 deck_ready", int'(deck_ready), 1);
    chk("52 cards_left", int'(cards_left), 52);
    chk("sticky load_error", int'(load_error), 1);
    send(3);
    chk("ready ign cards_left", int'(cards_left), 52);
    chk("ready ign deck_ready", int'(deck_ready), 1);
    chk("ready ign deal_error", int'(deal_error), 0);

    deal();
    chk("d7 deal_valid", int'(deal_valid), 1);
    chk("d7 card", int'(deal_card), 7);
    chk("d7 rank", int'(deal_rank), 8);
    chk("d7 points", int'(deal_points), 8);
    cyc();
    chk("hold deal_valid", int'(deal_valid), 0);
    chk("hold card", int'(deal_card), 7);
    chk("hold rank", int'(deal_rank), 8);

    // decode table
    for (int i = 0; i < 12; i++) begin
      deal();
      chk("tbl valid", int'(deal_valid), 1);
      chk("tbl card", int'(deal_card), tbl[i].card);
      chk("tbl rank", int'(deal_rank), tbl[i].rank);
      chk("tbl suit", int'(deal_suit), tbl[i].suit);
      chk("tbl points", int'(deal_points), tbl[i].points);
      cyc();
    end
    chk("tbl cards_left", int'(cards_left), 39);
    for (int i = 0; i < 9; i++) deal();
    chk("pre nd cards_left", int'(cards_left), 30);
    chk("pre nd card", int'(deal_card), order[21]);

    // new_deck beats simultaneous deal_req
    new_deck = 1'b1;
    deal_req = 1'b1;
    cyc();
    new_deck = 1'b0;
    deal_req = 1'b0;
    chk("prio deal_valid", int'(deal_valid), 0);
    chk("prio deal_error", int'(deal_error), 0);
    chk("prio cards_left", int'(cards_left), 0);
    chk("prio deck_ready", int'(deck_ready), 0);
    chk("prio load_error", int'(load_error), 0);
    chk("prio shuffle_req t1", int'(shuffle_req), 0);
    cyc();
    chk("prio shuffle_req t2", int'(shuffle_req), 1);

    // reset in the middle of a load
    for (int k = 0; k < 20; k++) send(k);
    send(5);
    chk("mid load_error", int'(load_error), 1);
    #2 rst = 1'b0;
    #1;
    chk_idle_outs("midrst");
    cyc();
    rst = 1'b1;
    cyc();
    for (int k = 0; k < 52; k++) send(k);
    chk("reload deck_ready", int'(deck_ready), 1);
    chk("reload cards_left", int'(cards_left), 52);
    chk("reload load_error", int'(load_error), 0);
    deal();
    chk("reload card", int'(deal_card), 0);
    chk("reload rank", int'(deal_rank), 1);
    chk("reload points", int'(deal_points), 11);
    chk("reload left", int'(cards_left), 51);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/deck_dealer.md
Name: deck_dealer

Overview:
- Sits directly downstream of the shuffle stage and upstream of the blackjack game controller.
- Captures the 52-card shuffled deck streamed from the shuffle stage into local storage and verifies it is a full permutation.
- Deals cards one at a time on request, with rank, suit and blackjack point value decoded.
- Tracks cards remaining and requests a fresh shuffle when a new deck is needed.

Parameters:
- DECK_SIZE, 52, cards per deck; card codes 0..DECK_SIZE-1.
- RESHUFFLE_THRESHOLD, 15, low-deck warning level: low_deck asserts when cards_left <= this value.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- card_valid  in  1  one-cycle strobe: card_in holds a new shuffled card
- card_in  in  6  card code from shuffle stage; suit = code/13, rank index = code%13
- deal_req  in  1  one-cycle strobe from controller requesting the next card
- new_deck  in  1  one-cycle strobe: discard current deck, request reshuffle
- shuffle_req  out  1  level: upstream must shuffle and stream a deck
- deck_ready  out  1  deck fully loaded and dealing permitted
- deal_valid  out  1  one-cycle strobe: deal_* outputs are valid
- deal_card  out  6  dealt card code
- deal_rank  out  4  1..13 (1=ace, 11=J, 12=Q, 13=K)
- deal_suit  out  2  0..3
- deal_points  out  4  ace=11, 2..10 face value, J/Q/K=10
- cards_left  out  6  undealt cards, 0..52
- low_deck  out  1  cards_left <= RESHUFFLE_THRESHOLD while READY
- deal_error  out  1  one-cycle strobe: illegal deal_req
- load_error  out  1  sticky: out-of-range or duplicate card received during load

Behaviour:
- Reset values (rst low, asynchronous):
  - State IDLE; wr_ptr = 0, rd_ptr = 0; seen mask cleared.
  - cards_left = 0; deal_* = 0; deal_valid = 0; deck_ready = 0; deal_error = 0; load_error = 0; shuffle_req = 0.
- States: IDLE, LOAD, READY, EMPTY.
- IDLE:
  - shuffle_req = 1.
  - The first card_valid moves to LOAD, and that card is processed as a LOAD-state card in the same cycle.
- LOAD:
  - shuffle_req stays 1.
  - On each card_valid:
    - If card_in >= 52 or seen[card_in] = 1: set load_error; drop the card; wr_ptr does not advance.
    - Otherwise: write deck[wr_ptr] = card_in, set seen[card_in], increment wr_ptr.
  - When the 52nd accepted card is written, the next cycle has state = READY, deck_ready = 1, shuffle_req = 0, cards_left = 52, rd_ptr = 0.
- READY:
  - deal_req produces exactly 1-cycle latency. On the next cycle:
    - deal_valid = 1; deal_card = deck[rd_ptr]; rank/suit/points are decoded from it.
    - rd_ptr increments; cards_left decrements.
  - deal_* outputs hold their last value when deal_valid = 0.
  - Back-to-back deal_req on consecutive cycles is legal: one card per cycle.
  - The deal that makes cards_left = 0 moves to EMPTY; deck_ready drops in the same cycle as that deal_valid.
- EMPTY:
  - deal_req gives deal_error = 1 on the next cycle; no deal_valid.
  - Stays in EMPTY until new_deck.
- deal_req in IDLE, LOAD or EMPTY gives a one-cycle deal_error; state is unchanged.
- card_valid in READY or EMPTY is ignored with no error.
- new_deck in any state:
  - Next cycle: IDLE; pointers, seen mask, cards_left and deck_ready cleared; load_error cleared.
  - The cycle after that, shuffle_req = 1.
  - new_deck has priority over a simultaneous deal_req (no deal, no error) and over a simultaneous card_valid (card dropped).
- Decode is combinational from the stored code, registered with deal_valid:
  - rank = code%13 + 1; suit = code/13.
  - points = 11 if rank = 1; 10 if rank >= 10; else rank.
- Reset mid-load or mid-deal: everything returns to reset values immediately; no partial deck is retained.
- Width rules: cards_left never wraps below 0 or above 52; pointers are 6 bits, compared against DECK_SIZE.

Decomposition:
- Shared package: DECK_SIZE, SUIT_SIZE = 13, state encoding for IDLE/LOAD/READY/EMPTY, ace/face point constants.
- The shuffle stage and controller also import this package.
- One sub-module: card_decode (combinational code -> rank, suit, points), reusable by the controller for hand display.

Test Plan:
- Reset release, then stream card codes 51 down to 0, one every 2 cycles -> shuffle_req = 1 throughout load; one cycle after the last card, deck_ready = 1, shuffle_req = 0, cards_left = 52, load_error = 0.
- Loaded deck, first card 0, then deal_req -> next cycle deal_valid = 1, deal_card = 0, rank = 1, suit = 0, points = 11, cards_left = 51; card 25 -> rank 13, suit 1, points 10.
- 52 consecutive deal_req strobes -> 52 deal_valid pulses in load order; low_deck asserts when cards_left = 15; the 53rd deal_req gives deal_error, state EMPTY.
- During load send card 7 twice, then 60 -> load_error = 1 (sticky); wr_ptr advances once only; load completes only after 52 distinct cards.
- new_deck on the same cycle as deal_req while READY with cards_left = 30 -> no deal_valid, no deal_error; state IDLE, cards_left = 0, shuffle_req = 1 two cycles later.
- rst low midway through load (after 20 cards) -> all outputs at reset values immediately; after release, a full 52-card reload succeeds.
